qmfir_mac_engine: RTL

// Time-multiplexed FIR MAC datapath behind the qmfir PLB slave. The slave writes input samples to MEM0 and

---
 rtl/qmfir_mac_engine_pkg.sv | 22 ++
 rtl/qmfir_mac_engine_if.sv | 33 +++
 rtl/qmfir_mac_engine_round_sat.sv | 35 +++
 rtl/qmfir_mac_engine.sv | 128 ++++++++++++
 4 files changed

// File: rtl/qmfir_mac_engine_pkg.sv
// Shared widths, FSM encoding and pipeline constants for the qmfir MAC engine.
package qmfir_mac_engine_pkg;

    localparam int unsigned C_DATA_WIDTH  = 16;
    localparam int unsigned C_COEF_WIDTH  = 16;
    localparam int unsigned C_ACC_WIDTH   = 40;
    localparam int unsigned C_ADDR_WIDTH  = 10;
    localparam int unsigned C_SHIFT_WIDTH = 6;
    localparam int unsigned DRAIN_CYCLES  = 3;
    // Mirrored coefficient needs one extra bit to hold +2^(CW-1).
    localparam int unsigned PROD_WIDTH    = C_COEF_WIDTH + 1 + C_DATA_WIDTH;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StInit  = 3'd1,
        StMac   = 3'd2,
        StDrain = 3'd3,
        StWrite = 3'd4,
        StDone  = 3'd5
    } state_t;

endpackage

// File: rtl/qmfir_mac_engine_if.sv
// Register-bank controls and BRAM ports of the qmfir MAC engine.
interface qmfir_mac_engine_if;
    import qmfir_mac_engine_pkg::*;

    logic                     start;
    logic                     abort;
    logic [C_ADDR_WIDTH-1:0]  num_samples;
    logic [C_ADDR_WIDTH-1:0]  num_taps;
    logic                     hi_band;
    logic                     decim;
    logic [C_SHIFT_WIDTH-1:0] shift;
    logic [C_ADDR_WIDTH-1:0]  x_addr;
    logic [C_DATA_WIDTH-1:0]  x_data;
    logic [C_ADDR_WIDTH-1:0]  h_addr;
    logic [C_COEF_WIDTH-1:0]  h_data;
    logic [C_ADDR_WIDTH-1:0]  y_addr;
    logic [C_DATA_WIDTH-1:0]  y_data;
    logic                     y_we;
    logic                     busy;
    logic                     done;
    logic                     sat_flag;

    modport master (
        output start, abort, num_samples, num_taps, hi_band, decim, shift, x_data, h_data,
        input  x_addr, h_addr, y_addr, y_data, y_we, busy, done, sat_flag
    );

    modport slave (
        input  start, abort, num_samples, num_taps, hi_band, decim, shift, x_data, h_data,
        output x_addr, h_addr, y_addr, y_data, y_we, busy, done, sat_flag
    );

endinterface

// File: rtl/qmfir_mac_engine_round_sat.sv
// Rounding right-shift of the accumulator followed by saturation to the output word.
module qmfir_mac_engine_round_sat
    import qmfir_mac_engine_pkg::*;
(
    input  logic signed [C_ACC_WIDTH-1:0]   i_acc,
    input  logic        [C_SHIFT_WIDTH-1:0] i_shift,
    output logic        [C_DATA_WIDTH-1:0]  o_data,
    output logic                            o_clip
);
    // Wide enough for the rounding constant at the largest shift.
    localparam int unsigned EW = 66;
    localparam int unsigned DW = C_DATA_WIDTH;
    localparam logic signed [EW-1:0] SatMax = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] SatMin = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] w_rnd;
    logic signed [EW-1:0] w_shr;

    always_comb begin
        w_ext  = EW'(i_acc);
        w_rnd  = (i_shift != '0) ? (EW'(1) << (i_shift - 6'd1)) : '0;
        w_shr  = (w_ext + w_rnd) >>> i_shift;
        o_clip = 1'b0;
        o_data = w_shr[DW-1:0];
        if (w_shr > SatMax) begin
            o_clip = 1'b1;
            o_data = SatMax[DW-1:0];
        end else if (w_shr < SatMin) begin
            o_clip = 1'b1;
            o_data = SatMin[DW-1:0];
        end
    end

endmodule

// File: rtl/qmfir_mac_engine.sv
// Time-multiplexed FIR MAC: one tap per cycle, low/high (mirror) band, optional decimation by 2.
module qmfir_mac_engine
    import qmfir_mac_engine_pkg::*;
(
    input  logic               SPLB_Clk,
    input  logic               SPLB_Rst,
    qmfir_mac_engine_if.slave  bus
);
    localparam int unsigned AW = C_ADDR_WIDTH;
    localparam int unsigned CW = C_COEF_WIDTH;
    localparam int unsigned PW = PROD_WIDTH;

    state_t                   r_state, w_state_nxt;
    logic [AW-1:0]            r_num_samples, r_num_taps, r_n, r_k;
    logic                     r_hi_band, r_decim, r_sat;
    logic [C_SHIFT_WIDTH-1:0] r_shift;
    logic [1:0]               r_drain;
    logic                     r_p1_vld, r_p1_zero, r_p1_neg, r_p2_vld;
    logic signed [PW-1:0]     r_prod;
    logic signed [C_ACC_WIDTH-1:0] r_acc;

    logic                     w_start, w_abort, w_empty, w_last_tap, w_drain_end, w_last_out;
    logic [AW:0]              w_n_next;
    logic signed [CW:0]       w_coef, w_coef_sel;
    logic signed [PW-1:0]     w_coef_ext, w_x_ext, w_prod;
    logic [C_DATA_WIDTH-1:0]  w_y;
    logic                     w_clip;

    assign w_start     = (r_state == StIdle) && bus.start && !bus.abort;
    assign w_abort     = bus.abort && (r_state != StIdle);
    assign w_empty     = (r_num_samples == '0) || (r_num_taps == '0);
    assign w_last_tap  = (r_k == r_num_taps - AW'(1));
    assign w_drain_end = (r_drain == 2'(DRAIN_CYCLES - 1));
    assign w_n_next    = {1'b0, r_n} + (r_decim ? (AW+1)'(2) : (AW+1)'(1));
    assign w_last_out  = (w_n_next >= {1'b0, r_num_samples});

    always_ff @(posedge SPLB_Clk) begin
        if (SPLB_Rst) r_state <= StIdle;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_start) w_state_nxt = StInit;
            StInit:  w_state_nxt = w_empty ? StDone : StMac;
            StMac:   if (w_last_tap) w_state_nxt = StDrain;
            StDrain: if (w_drain_end) w_state_nxt = StWrite;
            StWrite: w_state_nxt = w_last_out ? StDone : StInit;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (w_abort) w_state_nxt = StIdle;
    end

    always_comb begin
        bus.x_addr   = r_n - r_k;
        bus.h_addr   = r_k;
        bus.y_addr   = r_decim ? (r_n >> 1) : r_n;
        bus.y_data   = w_y;
        bus.y_we     = (r_state == StWrite) && !bus.abort;
        bus.busy     = (r_state == StInit) || (r_state == StMac) ||
                       (r_state == StDrain) || (r_state == StWrite);
        bus.done     = (r_state == StDone) && !bus.abort;
        bus.sat_flag = r_sat;
    end

    // Stage 1 sees the BRAM data for the tap issued last cycle; x is zeroed where n-k < 0.
    always_comb begin
        w_coef     = $signed({bus.h_data[CW-1], bus.h_data});
        w_coef_sel = r_p1_neg ? -w_coef : w_coef;
        w_coef_ext = PW'(w_coef_sel);
        w_x_ext    = r_p1_zero ? '0 : PW'($signed(bus.x_data));
        w_prod     = w_coef_ext * w_x_ext;
    end

    always_ff @(posedge SPLB_Clk) begin
        if (SPLB_Rst) begin
            r_num_samples <= '0;
            r_num_taps    <= '0;
            r_hi_band     <= 1'b0;
            r_decim       <= 1'b0;
            r_shift       <= '0;
            r_n           <= '0;
            r_k           <= '0;
            r_drain       <= '0;
            r_sat         <= 1'b0;
            r_p1_vld      <= 1'b0;
            r_p1_zero     <= 1'b0;
            r_p1_neg      <= 1'b0;
            r_p2_vld      <= 1'b0;
            r_prod        <= '0;
            r_acc         <= '0;
        end else begin
            if (w_start) begin
                r_num_samples <= bus.num_samples;
                r_num_taps    <= bus.num_taps;
                r_hi_band     <= bus.hi_band;
                r_decim       <= bus.decim;
                r_shift       <= bus.shift;
                r_n           <= '0;
                r_sat         <= 1'b0;
            end
            if (r_state == StInit) r_k <= '0;
            else if (r_state == StMac && !w_last_tap) r_k <= r_k + AW'(1);
            r_drain <= (r_state == StDrain) ? r_drain + 2'd1 : 2'd0;
            if (r_state == StWrite && !bus.abort) begin
                r_n <= w_n_next[AW-1:0];
                if (w_clip) r_sat <= 1'b1;
            end
            r_p1_vld  <= (r_state == StMac) && !bus.abort;
            r_p1_zero <= (r_k > r_n);
            r_p1_neg  <= r_hi_band && r_k[0];
            r_p2_vld  <= r_p1_vld;
            r_prod    <= r_p1_vld ? w_prod : '0;
            if (r_state == StInit) r_acc <= '0;
            else if (r_p2_vld)     r_acc <= r_acc + C_ACC_WIDTH'(r_prod);
        end
    end

    qmfir_mac_engine_round_sat u_round_sat (
        .i_acc   (r_acc),
        .i_shift (r_shift),
        .o_data  (w_y),
        .o_clip  (w_clip)
    );

endmodule
